// File: rtl/param_serializer_if.sv
// param_serializer_if: word handshake and serial stream bundle; SER_PARITY_EN adds par_type/par_bit
interface param_serializer_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] p_data;
  logic data_valid;
  logic data_ready;
  logic ser_en;
  logic abort;
  logic ser_data;
  logic ser_done;
  logic busy;
`ifdef SER_PARITY_EN
  logic par_type;
  logic par_bit;
  modport master(output p_data, data_valid, ser_en, abort, par_type,
                 input data_ready, ser_data, ser_done, busy, par_bit);
  modport slave(input p_data, data_valid, ser_en, abort, par_type,
                output data_ready, ser_data, ser_done, busy, par_bit);
`else
  modport master(output p_data, data_valid, ser_en, abort,
                 input data_ready, ser_data, ser_done, busy);
  modport slave(input p_data, data_valid, ser_en, abort,
                output data_ready, ser_data, ser_done, busy);
`endif
endinterface

// File: rtl/param_serializer.sv
// param_serializer: parallel-to-serial shifter with one-word holding buffer; SER_PARITY_EN adds parity output
module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter logic SER_IDLE = 1'b0
) (
  input logic clk,
  input logic rst,
  param_serializer_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] hold, shr;
  logic [CW-1:0] cnt;
  logic hold_valid, ser_data, load, shift;
  assign load = state == IDLE && hold_valid;
  assign shift = state == SHIFT && bus.ser_en;
  assign bus.data_ready = rst || !hold_valid;
  assign bus.busy = !rst && (state != IDLE || hold_valid);
  assign bus.ser_done = state == DONE;
  assign bus.ser_data = ser_data;
  // state register; reset and abort both return to IDLE
  always_ff @(posedge clk) state <= (rst || bus.abort) ? IDLE : state_n;
  // next state: load from the buffer, shift DATA_WIDTH enabled bits, linger in DONE while enabled
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = hold_valid ? SHIFT : IDLE;
      SHIFT: state_n = (bus.ser_en && cnt == CW'(DATA_WIDTH - 1)) ? DONE : SHIFT;
      DONE: state_n = bus.ser_en ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // holding buffer, shift register, bit counter and registered serial output
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      hold <= '0;
      hold_valid <= 1'b0;
      shr <= '0;
      cnt <= '0;
      ser_data <= SER_IDLE;
    end else begin
      if (load) begin
        shr <= hold;
        hold_valid <= 1'b0;
        cnt <= '0;
      end else if (bus.data_valid && !hold_valid) begin
        hold <= bus.p_data;
        hold_valid <= 1'b1;
      end
      if (shift) begin
        ser_data <= MSB_FIRST ? shr[DATA_WIDTH-1] : shr[0];
        shr <= MSB_FIRST ? shr << 1 : shr >> 1;
        cnt <= cnt + CW'(1);
      end
    end
  end
`ifdef SER_PARITY_EN
  logic par_bit;
  assign bus.par_bit = par_bit;
  // parity of the word captured on load, stable until the next load
  always_ff @(posedge clk) par_bit <= (rst || bus.abort) ? 1'b0 : load ? ^hold ^ bus.par_type : par_bit;
`endif
endmodule

// File: tb/tb_param_serializer.sv
// tb_param_serializer: directed and randomized checks of param_serializer (LSB/8-bit and MSB/12-bit instances)
module tb_param_serializer;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  param_serializer_if #(.DATA_WIDTH(8)) a ();
  param_serializer_if #(.DATA_WIDTH(12)) b ();
  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .SER_IDLE(1'b0)) u8 (.clk(clk), .rst(rst), .bus(a.slave));
  param_serializer #(.DATA_WIDTH(12), .MSB_FIRST(1'b1), .SER_IDLE(1'b0)) u12 (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [31:0] w, input int width, input bit msb, input int i);
    return msb ? w[width-1-i] : w[i];
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] w, input int pause_at, input int pause_len, input int done_hold);
    a.p_data = w;
    a.data_valid = 1'b1;
    a.ser_en = 1'b1;
    step;
    a.data_valid = 1'b0;
    chk("accept_ready", a.data_ready, 0);
    chk("accept_busy", a.busy, 1);
    step;
    chk("load_done", a.ser_done, 0);
`ifdef SER_PARITY_EN
    chk("par_bit", a.par_bit, ^w ^ a.par_type);
`endif
    for (int i = 0; i < 8; i++) begin
      if (i == pause_at && pause_len > 0) begin
        a.ser_en = 1'b0;
        repeat (pause_len) begin
          step;
          chk($sformatf("pause_data%0d", i), a.ser_data, bit_at(w, 8, 0, i - 1));
          chk("pause_done", a.ser_done, 0);
        end
        a.ser_en = 1'b1;
      end
      step;
      chk($sformatf("lsb_bit%0d_w%0h", i, w), a.ser_data, bit_at(w, 8, 0, i));
      chk($sformatf("lsb_done%0d", i), a.ser_done, i == 7);
    end
    repeat (done_hold) begin
      step;
      chk("done_hold_data", a.ser_data, bit_at(w, 8, 0, 7));
      chk("done_hold_done", a.ser_done, 1);
    end
    a.ser_en = 1'b0;
    step;
    chk("exit_done", a.ser_done, 0);
    chk("exit_busy", a.busy, 0);
    chk("exit_ready", a.data_ready, 1);
    chk("exit_data", a.ser_data, bit_at(w, 8, 0, 7));
  endtask

  task automatic send12(input logic [11:0] w);
    b.p_data = w;
    b.data_valid = 1'b1;
    b.ser_en = 1'b1;
    step;
    b.data_valid = 1'b0;
    step;
    for (int i = 0; i < 12; i++) begin
      step;
      chk($sformatf("msb_bit%0d_w%0h", i, w), b.ser_data, bit_at(w, 12, 1, i));
      chk($sformatf("msb_done%0d", i), b.ser_done, i == 11);
    end
    b.ser_en = 1'b0;
    step;
    chk("msb_exit_done", b.ser_done, 0);
    chk("msb_exit_busy", b.busy, 0);
  endtask

  initial begin : main
    logic [7:0] words [3];
    logic exp_d [$];
    logic exp_done [$];
    logic [11:0] pat;
    int idx;
    int stalls;
    bit acc;
    a.p_data = '0; a.data_valid = 1'b0; a.ser_en = 1'b0; a.abort = 1'b0;
    b.p_data = '0; b.data_valid = 1'b0; b.ser_en = 1'b0; b.abort = 1'b0;
`ifdef SER_PARITY_EN
    a.par_type = 1'b0;
    b.par_type = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    step;
    chk("in_reset_ready", a.data_ready, 1);
    chk("in_reset_busy", a.busy, 0);
    step;
    rst = 1'b0;
    chk("rst_data", a.ser_data, 0);
    chk("rst_done", a.ser_done, 0);
    chk("rst_ready", a.data_ready, 1);
    chk("rst_busy", a.busy, 0);
    chk("rst_data12", b.ser_data, 0);
    chk("rst_busy12", b.busy, 0);
`ifdef SER_PARITY_EN
    chk("rst_par", a.par_bit, 0);
`endif
    a.ser_en = 1'b1;
    repeat (3) begin
      step;
      chk("idle_en_data", a.ser_data, 0);
      chk("idle_en_busy", a.busy, 0);
    end
    a.ser_en = 1'b0;
    send8(8'hA5, 0, 0, 1);
    send8(8'hA5, 3, 3, 0);
`ifdef SER_PARITY_EN
    a.par_type = 1'b0;
    send8(8'hA5, 0, 0, 0);
    chk("par_even_a5", a.par_bit, 0);
    a.par_type = 1'b1;
    send8(8'hA5, 0, 0, 0);
    chk("par_odd_a5", a.par_bit, 1);
`endif
    repeat (6) begin
`ifdef SER_PARITY_EN
      a.par_type = 1'($urandom);
`endif
      send8(8'($urandom), int'($urandom_range(1, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
    words = '{8'hA5, 8'h3C, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        exp_d.push_back(bit_at(words[k], 8, 0, i));
        exp_done.push_back(i == 7);
      end
      repeat (2) begin
        exp_d.push_back(bit_at(words[k], 8, 0, 7));
        exp_done.push_back(1'b0);
      end
    end
    a.p_data = words[0];
    a.data_valid = 1'b1;
    a.ser_en = 1'b1;
    step;
    idx = 1;
    stalls = 0;
    a.p_data = words[1];
    step;
    for (int n = 0; n < 30; n++) begin
      a.data_valid = idx < 3;
      a.p_data = idx < 3 ? words[idx] : 8'h00;
      acc = a.data_valid && a.data_ready;
      if (a.data_valid && !a.data_ready) stalls++;
      a.ser_en = !a.ser_done;
      step;
      if (acc) idx++;
      chk($sformatf("b2b_data%0d", n), a.ser_data, exp_d[n]);
      chk($sformatf("b2b_done%0d", n), a.ser_done, exp_done[n]);
    end
    a.data_valid = 1'b0;
    chk("b2b_accepted", idx, 3);
    chk("b2b_stalled", stalls > 0, 1);
    chk("b2b_busy", a.busy, 0);
    chk("b2b_ready", a.data_ready, 1);
    a.p_data = 8'h5A;
    a.data_valid = 1'b1;
    a.ser_en = 1'b1;
    step;
    a.p_data = 8'hC3;
    step;
    repeat (4) step;
    a.data_valid = 1'b0;
    chk("abort_pre_bit3", a.ser_data, bit_at(8'h5A, 8, 0, 3));
    chk("abort_pre_ready", a.data_ready, 0);
    a.abort = 1'b1;
    step;
    a.abort = 1'b0;
    chk("abort_data", a.ser_data, 0);
    chk("abort_ready", a.data_ready, 1);
    chk("abort_busy", a.busy, 0);
`ifdef SER_PARITY_EN
    chk("abort_par", a.par_bit, 0);
`endif
    repeat (12) begin
      step;
      chk("post_abort_done", a.ser_done, 0);
      chk("post_abort_busy", a.busy, 0);
      chk("post_abort_data", a.ser_data, 0);
    end
    a.ser_en = 1'b0;
    a.p_data = 8'h77;
    a.data_valid = 1'b1;
    a.abort = 1'b1;
    step;
    a.abort = 1'b0;
    a.data_valid = 1'b0;
    chk("abort_drop_ready", a.data_ready, 1);
    step;
    chk("abort_drop_busy", a.busy, 0);
    send12(12'hF0A);
    pat = 12'b1111_0000_1010;
    for (int i = 0; i < 12; i++) chk($sformatf("f0a_pattern%0d", i), bit_at(12'hF0A, 12, 1, i), pat[11-i]);
    repeat (3) send12(12'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
Parametrised successor to the UART TX 8-bit serializer. Converts a DATA_WIDTH-bit parallel word into a bit stream, one bit per SER_EN cycle, in a configurable bit order. Adds a one-word holding buffer with a valid/ready handshake, so the next word loads while the current one shifts. Also adds pause-on-SER_EN-low and a synchronous abort. Sits between the TX data source and the TX control FSM, which drives SER_EN and watches SER_DONE.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 0, bit order: 0 = bit 0 first, 1 = bit DATA_WIDTH-1 first.
SER_IDLE, 1'b0, value of SER_DATA after reset and after ABORT.

Ports:
CLK  input  1  clock; all logic is on the rising edge.
RST  input  1  synchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel word.
DATA_VALID  input  1  P_DATA is valid.
DATA_READY  output  1  holding buffer is empty; the word is accepted when DATA_VALID && DATA_READY.
SER_EN  input  1  shift enable from the TX FSM.
ABORT  input  1  synchronous flush of the current word and the buffered word.
SER_DATA  output  1  serial bit (registered).
SER_DONE  output  1  last bit of the word is on SER_DATA.
BUSY  output  1  high when state != IDLE or the holding buffer is full.

Behaviour:
- Reset (RST=1 at an edge) clears everything: state=IDLE, hold_valid=0, CNT=0, SER_DATA=SER_IDLE, SER_DONE=0. While in reset, DATA_READY=1 and BUSY=0. RST has priority over all other inputs.
- Holding buffer (HOLD, hold_valid):
  - DATA_READY = !hold_valid, combinational from the register.
  - On accept: HOLD<=P_DATA and hold_valid<=1.
  - DATA_VALID while DATA_READY=0 is ignored; the source must hold the word.
- Counter CNT has width $clog2(DATA_WIDTH+1).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, hold_valid=1: SHR<=HOLD, hold_valid<=0, CNT<=0, go to SHIFT. An accept is impossible in this same cycle (DATA_READY=0). The buffer reopens on the next cycle.
  - IDLE: SER_EN is ignored and SER_DATA holds its value.
  - SHIFT, SER_EN=1:
    - SER_DATA <= SHR[0] (LSB-first) or SHR[DATA_WIDTH-1] (MSB-first).
    - SHR shifts toward the output end.
    - CNT<=CNT+1.
    - When CNT==DATA_WIDTH-1, go to DONE.
  - SHIFT, SER_EN=0: pause. SHR, CNT and SER_DATA all hold. A pause does not reset the count.
  - DONE: SER_DONE=1, decoded from state, so it is high in the cycle the final bit appears on SER_DATA. SER_EN=1 keeps the block in DONE with SER_DATA held. SER_EN=0 goes to IDLE.
  - The first bit of a new word appears no earlier than 2 cycles after DONE exits (IDLE load, then a SHIFT edge).
- ABORT=1 at an edge from any state: state<=IDLE, hold_valid<=0, CNT<=0, SER_DATA<=SER_IDLE. A word offered in the same cycle is dropped, because ABORT wins over the accept.
- A new word may be accepted during SHIFT and DONE. A third word stalls on DATA_READY=0.

Optional Feature:
SER_PARITY_EN:
- Defined: adds input PAR_TYPE (1 bit; 0 = even, 1 = odd) and output PAR_BIT (1 bit).
  - On the IDLE->SHIFT load, PAR_BIT <= ^HOLD ^ PAR_TYPE.
  - PAR_BIT is stable until the next load.
  - Reset and ABORT set PAR_BIT=0.
- Undefined: both ports and the parity logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: RST=1 for 2 cycles, then 0 -> SER_DATA=0, SER_DONE=0, DATA_READY=1, BUSY=0. SER_EN pulses in IDLE leave SER_DATA=0.
2. LSB-first, DATA_WIDTH=8: 0xA5 accepted, SER_EN held high -> SER_DATA = 1,0,1,0,0,1,0,1. SER_DONE=1 only while the 8th bit is out. SER_EN=0 -> IDLE on the next edge, BUSY=0.
3. Pause: SER_EN low for 3 cycles after the 3rd bit -> SER_DATA and CNT frozen. On resume, exactly 8 bits total are sent and the order is intact.
4. Back-to-back: 0x3C offered during the 2nd bit of 0xA5 -> accepted, DATA_READY=0. 0xFF offered next stalls until 0x3C moves to SHR. Streams are 0xA5, 0x3C, 0xFF with none lost.
5. ABORT on the 4th bit with a word buffered -> IDLE next cycle, SER_DATA=SER_IDLE, DATA_READY=1, SER_DONE never asserts, and the buffered word is discarded.
6. MSB_FIRST=1, DATA_WIDTH=12, 0xF0A -> 1,1,1,1,0,0,0,0,1,0,1,0. With SER_PARITY_EN defined, 0xA5: PAR_TYPE=0 gives PAR_BIT=0; PAR_TYPE=1 gives PAR_BIT=1.
